led_mode_controller: RTL and testbench



---
 rtl/led_mode_controller_pkg.sv | 30 +++
 rtl/led_mode_controller_debounce_filter.sv | 57 +++++
 rtl/led_mode_controller.sv | 130 +++++++++++++
 tb/tb_led_mode_controller.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/led_mode_controller_pkg.sv
// Shared types and constants for the LED mode controller.
//   mode_e       : display mode, value equals the selecting switch index minus one
//   *_INIT       : pattern value loaded when a mode is entered
//   init_pattern : maps a mode to its entry pattern
package led_mode_controller_pkg;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_WALK  = 2'd1,
    MODE_COUNT = 2'd2,
    MODE_BLINK = 2'd3
  } mode_e;

  localparam logic [3:0] WALK_INIT  = 4'b0001;
  localparam logic [3:0] COUNT_INIT = 4'b0000;
  localparam logic [3:0] BLINK_INIT = 4'b1111;

  // PASS never reads the pattern register, so its entry value is arbitrary.
  function automatic logic [3:0] init_pattern(input mode_e mode);
    logic [3:0] pat;
    case (mode)
      MODE_WALK:  pat = WALK_INIT;
      MODE_COUNT: pat = COUNT_INIT;
      MODE_BLINK: pat = BLINK_INIT;
      default:    pat = 4'b0000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_mode_controller_debounce_filter.sv
// Single-switch conditioner: 2-flop synchroniser followed by a stability
// counter. The debounced level only follows the synchronised input once a
// mismatch has persisted for DEBOUNCE_LIMIT consecutive clocks.
// Ports:
//   i_Clk    : system clock
//   i_Rst    : asynchronous active-high reset
//   i_Switch : raw switch level, asynchronous to i_Clk
//   o_Switch : debounced level (raw-to-output latency 2 + DEBOUNCE_LIMIT edges)
module debounce_filter #(
  parameter int DEBOUNCE_LIMIT = 250000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Switch,
  output logic o_Switch
);

  localparam int CW = $clog2(DEBOUNCE_LIMIT + 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  always_comb begin
    sync1_d = i_Switch;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (sync2_q == state_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DEBOUNCE_LIMIT - 1)) begin
      // This edge is the DEBOUNCE_LIMIT-th consecutive mismatch.
      state_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_Switch = state_q;

endmodule

// File: rtl/led_mode_controller.sv
// Switch-driven LED pattern generator. Each switch is debounced; a press on
// switch N selects mode N-1 (PASS, WALK, COUNT, BLINK) and restarts it.
// Ports:
//   i_Clk, i_Rst          : system clock, asynchronous active-high reset
//   i_Switch_1..4         : raw switch levels, 1 = pressed
//   o_LED_1..4            : registered LED drive, 1 = on (LED_1 = pattern LSB)
//   o_Mode                : registered current mode
module led_mode_controller
  import led_mode_controller_pkg::*;
#(
  parameter int DEBOUNCE_LIMIT = 250000,
  parameter int CLKS_PER_TICK  = 6250000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Switch_1,
  input  logic       i_Switch_2,
  input  logic       i_Switch_3,
  input  logic       i_Switch_4,
  output logic       o_LED_1,
  output logic       o_LED_2,
  output logic       o_LED_3,
  output logic       o_LED_4,
  output logic [1:0] o_Mode
);

  localparam int TW = $clog2(CLKS_PER_TICK);

  logic [3:0]    sw_raw;
  logic [3:0]    sw_deb;
  logic [3:0]    deb_prev_q, deb_prev_d;
  logic [3:0]    press;

  mode_e         mode_q, mode_d;
  logic          mode_load;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [3:0]    pattern_q, pattern_d;
  logic [3:0]    led_q, led_d;

  assign sw_raw = {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1};

  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_1 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_raw[0]), .o_Switch(sw_deb[0]));
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_2 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_raw[1]), .o_Switch(sw_deb[1]));
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_3 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_raw[2]), .o_Switch(sw_deb[2]));
  debounce_filter #(.DEBOUNCE_LIMIT(DEBOUNCE_LIMIT)) u_deb_4 (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Switch(sw_raw[3]), .o_Switch(sw_deb[3]));

  // One-cycle press pulse on each debounced rising edge.
  assign deb_prev_d = sw_deb;
  assign press      = sw_deb & ~deb_prev_q;

  // State register.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      mode_q <= MODE_PASS;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Next-state: lowest-numbered pressed switch wins; any press reloads.
  always_comb begin
    mode_d    = mode_q;
    mode_load = 1'b0;
    if (press[0]) begin
      mode_d    = MODE_PASS;
      mode_load = 1'b1;
    end else if (press[1]) begin
      mode_d    = MODE_WALK;
      mode_load = 1'b1;
    end else if (press[2]) begin
      mode_d    = MODE_COUNT;
      mode_load = 1'b1;
    end else if (press[3]) begin
      mode_d    = MODE_BLINK;
      mode_load = 1'b1;
    end
  end

  // Output: LEDs reflect the current mode/pattern registers one edge later.
  always_comb begin
    led_d = pattern_q;
    if (mode_q == MODE_PASS) begin
      led_d = sw_deb;
    end
  end

  assign tick = (tick_cnt_q == TW'(CLKS_PER_TICK - 1));

  // Mode entry outranks a coincident tick: reload without advancing.
  always_comb begin
    tick_cnt_d = tick_cnt_q + TW'(1);
    pattern_d  = pattern_q;
    if (mode_load) begin
      tick_cnt_d = '0;
      pattern_d  = init_pattern(mode_d);
    end else if (tick) begin
      tick_cnt_d = '0;
      case (mode_q)
        MODE_WALK:  pattern_d = {pattern_q[2:0], pattern_q[3]};
        MODE_COUNT: pattern_d = pattern_q + 4'd1;
        MODE_BLINK: pattern_d = ~pattern_q;
        default:    pattern_d = pattern_q;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      deb_prev_q <= 4'b0000;
      tick_cnt_q <= '0;
      pattern_q  <= 4'b0000;
      led_q      <= 4'b0000;
    end else begin
      deb_prev_q <= deb_prev_d;
      tick_cnt_q <= tick_cnt_d;
      pattern_q  <= pattern_d;
      led_q      <= led_d;
    end
  end

  assign {o_LED_4, o_LED_3, o_LED_2, o_LED_1} = led_q;
  assign o_Mode = mode_q;

endmodule

// File: tb/tb_led_mode_controller.sv
module tb_led_mode_controller;

  localparam int LIM  = 4;
  localparam int CPT  = 8;
  localparam int HMAX = 4096;

  logic       i_Clk = 1'b0;
  logic       i_Rst;
  logic       i_Switch_1, i_Switch_2, i_Switch_3, i_Switch_4;
  logic       o_LED_1, o_LED_2, o_LED_3, o_LED_4;
  logic [1:0] o_Mode;

  led_mode_controller #(.DEBOUNCE_LIMIT(LIM), .CLKS_PER_TICK(CPT)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst),
    .i_Switch_1(i_Switch_1), .i_Switch_2(i_Switch_2),
    .i_Switch_3(i_Switch_3), .i_Switch_4(i_Switch_4),
    .o_LED_1(o_LED_1), .o_LED_2(o_LED_2), .o_LED_3(o_LED_3), .o_LED_4(o_LED_4),
    .o_Mode(o_Mode));

  always #5 i_Clk = ~i_Clk;

  int n_total = 0;
  int n_pass  = 0;

  task automatic check_eq(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_total++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
  endtask

  function automatic logic [3:0] led_obs();
    return {o_LED_4, o_LED_3, o_LED_2, o_LED_1};
  endfunction

  // Reference model: edge-indexed history of raw inputs; debounced level
  // flips when the last LIM synchronised samples all disagree with it;
  // pattern is a closed-form function of whole ticks elapsed since entry.
  logic [3:0] hist [0:HMAX-1];
  int         e    = 0;
  int         base = 1;
  logic [3:0] m_deb = '0, m_deb_prev = '0, m_led = '0;
  int         m_mode = 0;
  int         m_entry = 0;

  function automatic logic hbit(input int j, input int i);
    if (j < base || j < 0 || j >= HMAX) return 1'b0;
    return hist[j][i];
  endfunction

  function automatic logic [3:0] pat(input int mode, input int d);
    int k;
    k = d / CPT;
    case (mode)
      1:       return 4'(1 << (k % 4));
      2:       return 4'(k % 16);
      3:       return (k % 2 == 0) ? 4'hF : 4'h0;
      default: return 4'h0;
    endcase
  endfunction

  task automatic model_edge();
    logic [3:0] deb_n, press;
    logic       flip;
    m_led = (m_mode == 0) ? m_deb : pat(m_mode, e - 1 - m_entry);
    press = m_deb & ~m_deb_prev;
    deb_n = m_deb;
    for (int i = 0; i < 4; i++) begin
      flip = 1'b1;
      for (int j = e - 2 - LIM + 1; j <= e - 2; j++)
        if (hbit(j, i) == m_deb[i]) flip = 1'b0;
      if (flip) deb_n[i] = ~m_deb[i];
    end
    if (press != 4'b0000) begin
      m_entry = e;
      if (press[0])      m_mode = 0;
      else if (press[1]) m_mode = 1;
      else if (press[2]) m_mode = 2;
      else               m_mode = 3;
    end
    m_deb_prev = m_deb;
    m_deb      = deb_n;
  endtask

  task automatic model_reset();
    m_deb = '0; m_deb_prev = '0; m_led = '0; m_mode = 0; m_entry = 0;
    base = e + 1;
  endtask

  task automatic step(input logic [3:0] sw);
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = sw;
    if (e + 1 < HMAX) hist[e + 1] = sw;
    @(posedge i_Clk);
    e++;
    model_edge();
    #1;
    check_eq("led", led_obs(), m_led);
    check_eq("mode", {2'b00, o_Mode}, 4'(m_mode));
  endtask

  task automatic run(input logic [3:0] sw, input int n);
    for (int k = 0; k < n; k++) step(sw);
  endtask

  int first_rise;

  initial begin
    i_Rst = 1'b1;
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = 4'b0000;
    repeat (3) @(posedge i_Clk);
    #1;
    check_eq("reset_led", led_obs(), 4'b0000);
    check_eq("reset_mode", {2'b00, o_Mode}, 4'd0);
    @(negedge i_Clk);
    i_Rst = 1'b0;

    // Short glitch on switch 2 must be ignored.
    run(4'b0010, 3);
    run(4'b0000, 15);
    check_eq("glitch_led", led_obs(), 4'b0000);
    check_eq("glitch_mode", {2'b00, o_Mode}, 4'd0);

    // PASS: LED_1 follows switch 1 after 2+LIM+1 edges.
    first_rise = -1;
    for (int k = 1; k <= 20; k++) begin
      step(4'b0001);
      if (first_rise < 0 && o_LED_1 === 1'b1) first_rise = k;
    end
    check_eq("pass_latency", 4'(first_rise), 4'd7);
    check_eq("pass_led", led_obs(), 4'b0001);
    run(4'b0000, 12);

    // WALK through a full rotation.
    run(4'b0010, 10);
    run(4'b0000, 40);
    check_eq("walk_mode", {2'b00, o_Mode}, 4'd1);

    // COUNT for 17+ ticks, covering the 1111->0000 wrap.
    run(4'b0100, 10);
    run(4'b0000, 17 * CPT + 4);
    check_eq("count_mode", {2'b00, o_Mode}, 4'd2);

    // Simultaneous presses: switch 3 beats switch 4.
    run(4'b1100, 10);
    check_eq("simul_mode", {2'b00, o_Mode}, 4'd2);
    run(4'b0000, 12);

    // BLINK, then reset mid-tick.
    run(4'b1000, 10);
    check_eq("blink_led", led_obs(), 4'b1111);
    i_Rst = 1'b1;
    #1;
    check_eq("rst_led", led_obs(), 4'b0000);
    check_eq("rst_mode", {2'b00, o_Mode}, 4'd0);
    {i_Switch_4, i_Switch_3, i_Switch_2, i_Switch_1} = 4'b0000;
    @(posedge i_Clk);
    @(negedge i_Clk);
    i_Rst = 1'b0;
    model_reset();
    run(4'b0000, 30);
    check_eq("post_rst_led", led_obs(), 4'b0000);

    // Randomized segments, mostly idle with occasional multi-switch presses.
    for (int s = 0; s < 120; s++) begin
      logic [3:0] sw;
      sw = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0000;
      run(sw, $urandom_range(1, 10));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
